// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM encodings and handshake levels.
package div_iter_pkg;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem < divisor always holds, so the top bit of the DATA_W+1 bit difference is its sign.
  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[DATA_W];
  assign rem_nxt = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle, {remainder, quotient} result.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic              neg_quo;
  logic              neg_rem;

  logic [DATA_W-1:0] rem_nxt;
  logic              q_bit;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;

  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                     accept;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic                     is_signed);
    return (is_signed && v < 0) ? negate(v) : v;
  endfunction

  assign op1_s  = opdata1_i;
  assign op2_s  = opdata2_i;
  assign accept = (state == DIV_FREE) && (start_i == DIV_START) && !annul_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[DATA_W-1]),
    .divisor (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // The dividend register doubles as the quotient register: bits shift out the top, quotient bits in the bottom.
  assign quo_nxt = {dvd[DATA_W-2:0], q_bit};
  assign quo_fix = neg_quo ? negate(quo_nxt) : quo_nxt;
  assign rem_fix = neg_rem ? negate(rem_nxt) : rem_nxt;

  // Operand / datapath registers
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= '0;
      dvd     <= magnitude(op1_s, signed_div_i);
      dvs     <= magnitude(op2_s, signed_div_i);
      neg_quo <= signed_div_i && (op1_s[DATA_W-1] ^ op2_s[DATA_W-1]);
      neg_rem <= signed_div_i && op1_s[DATA_W-1];
    end else if (state == DIV_ON) begin
      rem <= rem_nxt;
      dvd <= quo_nxt;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (accept) begin
            cnt   <= '0;
            state <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result_o <= '0;
          state    <= annul_i ? DIV_FREE : DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt == LAST_STEP) begin
            state    <= DIV_END;
            cnt      <= '0;
            ready_o  <= DIV_RESULT_READY;
            result_o <= {rem_fix, quo_fix};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // END: hold the result until EX drops start; annul has no effect here.
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end else begin
            ready_o <= DIV_RESULT_READY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide-by-zero, annul, reset and hold behaviour.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands with start high and clock the acceptance edge.
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
  endtask

  // Counts edges after acceptance until ready_o rises, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drop_start(input string tag);
    start_i = 1'b0;
    tick();
    chk({tag, "_rdy_low"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_res_zero"}, result_o, 64'd0);
  endtask

  initial begin
    int lat;
    logic saw_ready;

    resetn       = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk("reset_rdy", {63'd0, ready_o}, 64'd0);
    chk("reset_res", result_o, 64'd0);
    resetn = 1'b1;
    tick();

    // 1: unsigned 100/7, exact 32-cycle latency
    start_div(1'b0, 32'd100, 32'd7);
    repeat (31) tick();
    chk("t1_rdy_edge31", {63'd0, ready_o}, 64'd0);
    tick();
    chk("t1_rdy_edge32", {63'd0, ready_o}, 64'd1);
    chk("t1_res", result_o, {32'd2, 32'd14});
    drop_start("t1");

    // 2: signed -7/2 and 7/-2
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(lat);
    chk("t2a_lat", 64'(lat), 64'd32);
    chk("t2a_res", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drop_start("t2a");
    start_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(lat);
    chk("t2b_lat", 64'(lat), 64'd32);
    chk("t2b_res", result_o, {32'd1, 32'hFFFF_FFFD});
    drop_start("t2b");

    // unsigned interpretation of the same bit pattern: 0xFFFFFFF9/2
    start_div(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_ready(lat);
    chk("t2c_res", result_o, {32'd1, 32'h7FFF_FFFC});
    drop_start("t2c");

    // 3: divide by zero, both modes
    start_div(1'b0, 32'd5, 32'd0);
    chk("t3u_rdy_edge0", {63'd0, ready_o}, 64'd0);
    wait_ready(lat);
    chk("t3u_lat", 64'(lat), 64'd2);
    chk("t3u_res", result_o, 64'd0);
    drop_start("t3u");
    start_div(1'b1, 32'd5, 32'd0);
    wait_ready(lat);
    chk("t3s_lat", 64'(lat), 64'd2);
    chk("t3s_res", result_o, 64'd0);
    drop_start("t3s");

    // 4: annul at ON step 10, ready must never rise
    start_div(1'b0, 32'd100, 32'd7);
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i   = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o !== 1'b0) saw_ready = 1'b1;
      tick();
    end
    chk("t4_no_ready", {63'd0, saw_ready}, 64'd0);
    chk("t4_res_zero", result_o, 64'd0);

    // 4/5: 9/3 after annul, then hold start in END while operands wander
    start_div(1'b0, 32'd9, 32'd3);
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'd0;
    wait_ready(lat);
    chk("t4_lat", 64'(lat), 64'd32);
    chk("t4_res", result_o, {32'd0, 32'd3});
    for (int i = 0; i < 5; i++) begin
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      annul_i   = i[0];
      tick();
      chk($sformatf("t5_hold_rdy%0d", i), {63'd0, ready_o}, 64'd1);
      chk($sformatf("t5_hold_res%0d", i), result_o, {32'd0, 32'd3});
    end
    annul_i = 1'b0;
    drop_start("t5");

    // 6: reset at ON step 20 discards the operation
    start_div(1'b0, 32'd100, 32'd7);
    repeat (20) tick();
    resetn  = 1'b0;
    start_i = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_rst_rdy", {63'd0, ready_o}, 64'd0);
    chk("t6_rst_res", result_o, 64'd0);
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready_o !== 1'b0) saw_ready = 1'b1;
      tick();
    end
    chk("t6_no_ready", {63'd0, saw_ready}, 64'd0);

    // signed overflow 0x80000000 / -1
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(lat);
    chk("t6_ovf_lat", 64'(lat), 64'd32);
    chk("t6_ovf_res", result_o, {32'd0, 32'h8000_0000});
    drop_start("t6_ovf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
